// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU arbiter package.
// ALUop encodings and default datapath widths.
package alu_share_arbiter_pkg;

  localparam int ALU_W   = 32;
  localparam int ALU_OPW = 4;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_SLL    = 4'd5,
    OP_SRL    = 4'd6,
    OP_SRA    = 4'd7,
    OP_SLT    = 4'd8,
    OP_SLTU   = 4'd9,
    OP_COPY_B = 4'd10
  } alu_op_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester, ALU and response bundle.
// slave is the arbiter side, master the environment.
interface alu_share_arbiter_if
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = ALU_W,
  parameter int OPW  = ALU_OPW,
  parameter int SRCW = 2
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_A;
  logic [NREQ*W-1:0]   req_B;
  logic [NREQ*OPW-1:0] req_op;
  logic [W-1:0]        alu_A;
  logic [W-1:0]        alu_B;
  logic [OPW-1:0]      alu_op;
  logic [W-1:0]        alu_out;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [W-1:0]        rsp_data;
  logic [SRCW-1:0]     rsp_src;
  logic                busy;

  modport slave (
    input  req_valid, req_A, req_B, req_op,
    input  alu_out, rsp_ready,
    output req_ready, alu_A, alu_B, alu_op,
    output rsp_valid, rsp_data, rsp_src, busy
  );

  modport master (
    output req_valid, req_A, req_B, req_op,
    output alu_out, rsp_ready,
    input  req_ready, alu_A, alu_B, alu_op,
    input  rsp_valid, rsp_data, rsp_src, busy
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr_i.
// Purely combinational, one-hot grant plus its index.
module alu_share_arbiter_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int SRCW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [SRCW-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [SRCW-1:0] idx_o,
  output logic            any_o
);
  int   j;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!found && req_i[j]) begin
        grant_o[j] = 1'b1;
        idx_o      = SRCW'(j);
        found      = 1'b1;
      end
    end
  end

  assign any_o = found;
endmodule

// File: rtl/alu_share_arbiter.sv
// Two-stage issue/response pipeline sharing one
// external ALU between NREQ round-robin requesters.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = ALU_W,
  parameter int OPW  = ALU_OPW,
  parameter int SRCW = 2
) (
  input  logic clk,
  input  logic rst_n,
  alu_share_arbiter_if.slave bus
);
  logic [NREQ-1:0] grant;
  logic [SRCW-1:0] gidx;
  logic            gany;

  logic            s1_valid_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [OPW-1:0]  op_q;
  logic [SRCW-1:0] src_q;
  logic [SRCW-1:0] rr_q;
  logic [SRCW-1:0] rr_d;

  logic            rsp_valid_q;
  logic [W-1:0]    rsp_data_q;
  logic [SRCW-1:0] rsp_src_q;

  logic s2_take;
  logic s1_move;
  logic s1_take;
  logic accept;

  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic [OPW-1:0] sel_op;

  alu_share_arbiter_rr_arbiter #(
    .NREQ(NREQ),
    .SRCW(SRCW)
  ) u_rr (
    .req_i  (bus.req_valid),
    .ptr_i  (rr_q),
    .grant_o(grant),
    .idx_o  (gidx),
    .any_o  (gany)
  );

  assign s2_take = !rsp_valid_q | bus.rsp_ready;
  assign s1_move = s1_valid_q & s2_take;
  assign s1_take = !s1_valid_q | s1_move;
  assign accept  = gany & s1_take;

  // Held low in reset so nothing looks accepted.
  assign bus.req_ready =
    grant & {NREQ{s1_take & rst_n}};

  assign rr_d = (gidx == SRCW'(NREQ-1))
              ? '0 : gidx + 1'b1;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a  = bus.req_A[i*W +: W];
        sel_b  = bus.req_B[i*W +: W];
        sel_op = bus.req_op[i*OPW +: OPW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      src_q       <= '0;
      rr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_src_q   <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        a_q        <= sel_a;
        b_q        <= sel_b;
        op_q       <= sel_op;
        src_q      <= gidx;
        rr_q       <= rr_d;
      end else if (s1_move) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_take) begin
        rsp_valid_q <= s1_valid_q;
      end
      if (s1_move) begin
        rsp_data_q <= bus.alu_out;
        rsp_src_q  <= src_q;
      end
    end
  end

  assign bus.alu_A     = a_q;
  assign bus.alu_B     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_src   = rsp_src_q;
  assign bus.busy      = s1_valid_q | rsp_valid_q;
endmodule
